stage_skid_reg: RTL

Parametrised pipeline stage register with a valid/ready handshake. It is the successor to the fixed-width ID/EX style stage flop: it carries an arbitrary packed payload and replaces the global stall with per-stage backpressure. An optional two-entry skid buffer gives a fully registered `in_ready`, and a flush kills every held entry. It sits between any two pipeline stages (IF/ID, ID/EX, EX/MEM); the payload is the concatenated stage bundle.

---
 rtl/stage_skid_reg_pkg.sv | 23 ++
 rtl/stage_skid_reg_sat_counter.sv | 34 +++
 rtl/stage_skid_reg.sv | 113 +++++++++++
 3 files changed

// File: rtl/stage_skid_reg_pkg.sv
// rtl/stage_skid_reg_pkg.sv - shared pipeline stage state type and payload widths
package stage_skid_reg_pkg;

    localparam int IFID_W  = 96;
    localparam int IDEX_W  = 341;
    localparam int EXMEM_W = 206;

    // Encoding doubles as the held-entry count.
    typedef enum logic [1:0] {
        STG_EMPTY = 2'd0,
        STG_ONE   = 2'd1,
        STG_TWO   = 2'd2
    } stg_state_e;

    function automatic logic [1:0] stg_count(stg_state_e s);
        case (s)
            STG_ONE: return 2'd1;
            STG_TWO: return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/stage_skid_reg_sat_counter.sv
// rtl/stage_skid_reg_sat_counter.sv - saturating event counter with synchronous clear
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (inc && (q_q != {W{1'b1}})) begin
            q_d = q_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/stage_skid_reg.sv
// rtl/stage_skid_reg.sv - valid/ready pipeline stage register with optional two-entry skid
module stage_skid_reg
    import stage_skid_reg_pkg::*;
#(
    parameter int               WIDTH     = IDEX_W,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter bit               SKID      = 1'b1,
    parameter int               CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count,
    input  logic             stat_clr,
    output logic [CNT_W-1:0] bp_cycles
);

    stg_state_e       state_q;
    stg_state_e       state_d;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] skid_q;
    logic [WIDTH-1:0] skid_d;
    logic             in_fire;
    logic             out_fire;

    assign out_valid = (state_q != STG_EMPTY);
    assign out_data  = main_q;
    assign count     = stg_count(state_q);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    generate
        if (SKID) begin : g_skid_ready
            // Registered ready: only depends on held state.
            assign in_ready = (state_q != STG_TWO) & ~rst;
        end else begin : g_flop_ready
            assign in_ready = (~out_valid | out_ready) & ~rst;
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            STG_EMPTY: begin
                if (in_fire) begin
                    main_d  = in_data;
                    state_d = STG_ONE;
                end
            end
            STG_ONE: begin
                if (in_fire && out_fire) begin
                    main_d = in_data;
                end else if (out_fire) begin
                    main_d  = RESET_VAL;
                    state_d = STG_EMPTY;
                end else if (in_fire && SKID) begin
                    skid_d  = in_data;
                    state_d = STG_TWO;
                end
            end
            STG_TWO: begin
                if (out_fire) begin
                    main_d  = skid_q;
                    skid_d  = RESET_VAL;
                    state_d = STG_ONE;
                end
            end
            default: begin
                main_d  = RESET_VAL;
                skid_d  = RESET_VAL;
                state_d = STG_EMPTY;
            end
        endcase
        // Interface transfers still happen; only the held contents are killed.
        if (flush) begin
            main_d  = RESET_VAL;
            skid_d  = RESET_VAL;
            state_d = STG_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= STG_EMPTY;
            main_q  <= RESET_VAL;
            skid_q  <= RESET_VAL;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= SKID ? skid_d : RESET_VAL;
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_bp_cnt (
        .clk (clk),
        .rst (rst),
        .clr (stat_clr),
        .inc (out_valid & ~out_ready),
        .q   (bp_cycles)
    );

endmodule
